// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty thresholds,
// sticky overflow/underflow flags and a selectable registered or fall-through read port.
module sync_fifo_flags #(
  parameter int unsigned ADD      = 3,
  parameter int unsigned DATA     = 8,
  parameter int unsigned AF_LEVEL = 6,
  parameter int unsigned AE_LEVEL = 2,
  parameter bit          FWFT     = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            w_en,
  input  logic [DATA-1:0] wdata,
  input  logic            r_en,
  output logic [DATA-1:0] rdata,
  output logic            rvalid,
  output logic            full,
  output logic            empty,
  output logic            almost_full,
  output logic            almost_empty,
  output logic [ADD:0]    count,
  output logic            overflow,
  output logic            underflow
);

  localparam int unsigned DEPTH = 1 << ADD;

  localparam logic [ADD:0] CntOne   = (ADD+1)'(1);
  localparam logic [ADD:0] CntDepth = (ADD+1)'(DEPTH);
  localparam logic [ADD:0] CntAf    = (ADD+1)'(AF_LEVEL);
  localparam logic [ADD:0] CntAe    = (ADD+1)'(AE_LEVEL);

  logic [DATA-1:0] mem [DEPTH];

  logic [ADD:0] wptr_q, wptr_d;
  logic [ADD:0] rptr_q, rptr_d;
  logic [ADD:0] count_q, count_d;
  logic         full_q, full_d;
  logic         empty_q, empty_d;
  logic         afull_q, afull_d;
  logic         aempty_q, aempty_d;
  logic         overflow_q, overflow_d;
  logic         underflow_q, underflow_d;

  logic wacc;
  logic racc;

  // Acceptance uses this cycle's registered flags, so a simultaneous pop never
  // frees room for a write to a full FIFO (and vice versa for empty).
  assign wacc = w_en && !full_q;
  assign racc = r_en && !empty_q;

  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q | (w_en & full_q);
    underflow_d = underflow_q | (r_en & empty_q);

    if (wacc) begin
      wptr_d = wptr_q + CntOne;
    end
    if (racc) begin
      rptr_d = rptr_q + CntOne;
    end

    unique case ({wacc, racc})
      2'b10:   count_d = count_q + CntOne;
      2'b01:   count_d = count_q - CntOne;
      default: count_d = count_q;
    endcase

    full_d   = (count_d == CntDepth);
    empty_d  = (count_d == '0);
    afull_d  = (count_d >= CntAf);
    aempty_d = (count_d <= CntAe);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      afull_q     <= 1'b0;
      aempty_q    <= 1'b1;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      afull_q     <= afull_d;
      aempty_q    <= aempty_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is deliberately not reset; the reset cycle still blocks writes.
  always_ff @(posedge clk) begin
    if (!rst && wacc) begin
      mem[wptr_q[ADD-1:0]] <= wdata;
    end
  end

  if (FWFT) begin : g_fwft
    assign rdata  = mem[rptr_q[ADD-1:0]];
    assign rvalid = !empty_q;
  end else begin : g_reg_read
    logic [DATA-1:0] rdata_q;
    logic            rvalid_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        rdata_q  <= '0;
        rvalid_q <= 1'b0;
      end else begin
        rvalid_q <= racc;
        if (racc) begin
          rdata_q <= mem[rptr_q[ADD-1:0]];
        end
      end
    end

    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;
  end

  assign count        = count_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Scoreboard bench: a registered-read instance driven through a cycle model,
// plus a fall-through instance exercised with short directed sequences.
module tb_sync_fifo_flags;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       w_en = 1'b0;
  logic [7:0] wdata = 8'h00;
  logic       r_en = 1'b0;
  logic [7:0] rdata;
  logic       rvalid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [3:0] count;

  logic       f_w_en = 1'b0;
  logic [7:0] f_wdata = 8'h00;
  logic       f_r_en = 1'b0;
  logic [7:0] f_rdata;
  logic       f_rvalid, f_full, f_empty, f_almost_full, f_almost_empty;
  logic       f_overflow, f_underflow;
  logic [3:0] f_count;

  always #5 clk = ~clk;

  sync_fifo_flags #(
    .ADD(3), .DATA(8), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .w_en(w_en), .wdata(wdata), .r_en(r_en),
    .rdata(rdata), .rvalid(rvalid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  sync_fifo_flags #(
    .ADD(3), .DATA(8), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(1'b1)
  ) dut_fwft (
    .clk(clk), .rst(rst), .w_en(f_w_en), .wdata(f_wdata), .r_en(f_r_en),
    .rdata(f_rdata), .rvalid(f_rvalid), .full(f_full), .empty(f_empty),
    .almost_full(f_almost_full), .almost_empty(f_almost_empty), .count(f_count),
    .overflow(f_overflow), .underflow(f_underflow)
  );

  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;

  // Model state for the registered-read instance
  logic [7:0] sb[$];
  int         m_count = 0;
  logic       m_ovf = 1'b0;
  logic       m_unf = 1'b0;
  logic [7:0] m_rdata = 8'h00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_state(input logic exp_rvalid);
    check("count", 32'(count), 32'(m_count));
    check("empty", 32'(empty), 32'(m_count == 0));
    check("full", 32'(full), 32'(m_count == 8));
    check("almost_empty", 32'(almost_empty), 32'(m_count <= 2));
    check("almost_full", 32'(almost_full), 32'(m_count >= 6));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("underflow", 32'(underflow), 32'(m_unf));
    check("rvalid", 32'(rvalid), 32'(exp_rvalid));
    check("rdata", 32'(rdata), 32'(m_rdata));
  endtask

  // One clock of stimulus on the registered-read instance, then compare.
  task automatic step(input logic w, input logic [7:0] d, input logic r);
    logic wacc, racc;
    wacc = w && (m_count != 8);
    racc = r && (m_count != 0);
    if (w && m_count == 8) m_ovf = 1'b1;
    if (r && m_count == 0) m_unf = 1'b1;
    if (wacc) sb.push_back(d);
    if (racc) m_rdata = sb.pop_front();
    m_count = m_count + int'(wacc) - int'(racc);
    w_en  = w;
    wdata = d;
    r_en  = r;
    @(posedge clk);
    #1;
    w_en = 1'b0;
    r_en = 1'b0;
    check_state(racc);
  endtask

  task automatic do_reset(input int cycles, input logic with_write);
    rst   = 1'b1;
    w_en  = with_write;
    wdata = 8'hEE;
    repeat (cycles) @(posedge clk);
    #1;
    rst  = 1'b0;
    w_en = 1'b0;
    sb.delete();
    m_count = 0;
    m_ovf   = 1'b0;
    m_unf   = 1'b0;
    m_rdata = 8'h00;
  endtask

  initial begin
    // Reset release
    do_reset(2, 1'b0);
    step(1'b0, 8'h00, 1'b0);

    // Fill 0x01..0x08, rejected 9th write, drain
    for (int i = 1; i <= 8; i++) step(1'b1, 8'(i), 1'b0);
    step(1'b1, 8'hFF, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);

    // Underflow stays sticky
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0);

    // Simultaneous ops at count=4 across pointer wrap
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h40 + i), 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 8'(8'h80 + i), 1'b1);

    // Simultaneous at full and at empty
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'hC0 + i), 1'b0);
    step(1'b1, 8'h99, 1'b1);
    for (int i = 0; i < 7; i++) step(1'b0, 8'h00, 1'b1);
    step(1'b1, 8'h5A, 1'b1);
    step(1'b0, 8'h00, 1'b1);

    // Reset mid-operation with a write in the reset cycle
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h10 + i), 1'b0);
    do_reset(1, 1'b1);
    check_state(1'b0);
    step(1'b1, 8'h3C, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);

    // Fall-through instance
    f_w_en  = 1'b1;
    f_wdata = 8'hA5;
    @(posedge clk);
    #1;
    f_w_en = 1'b0;
    check("f_rvalid_after_write", 32'(f_rvalid), 32'd1);
    check("f_rdata_after_write", 32'(f_rdata), 32'hA5);
    check("f_empty_after_write", 32'(f_empty), 32'd0);
    f_r_en = 1'b1;
    @(posedge clk);
    #1;
    f_r_en = 1'b0;
    check("f_empty_after_pop", 32'(f_empty), 32'd1);
    check("f_rvalid_after_pop", 32'(f_rvalid), 32'd0);
    for (int i = 0; i < 2; i++) begin
      f_w_en  = 1'b1;
      f_wdata = 8'(8'h61 + i);
      @(posedge clk);
      #1;
    end
    f_w_en = 1'b0;
    check("f_head_first", 32'(f_rdata), 32'h61);
    f_r_en = 1'b1;
    @(posedge clk);
    #1;
    f_r_en = 1'b0;
    check("f_head_next", 32'(f_rdata), 32'h62);
    check("f_count", 32'(f_count), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
